// File: rtl/rmw_long_latency_tbl.sv
// Long-latency state table: fixed-latency pipelined reads, single-cycle writes.
// Optional macro RMW_LONG_LATENCY_TBL_SNOOP_EN: in-flight reads pick up writes to their id.
module rmw_long_latency_tbl #(
   parameter int unsigned W     = 32,
   parameter int unsigned ID_W  = 4,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned LAT   = 4,
   localparam int unsigned CNT_W = $clog2(LAT + 1) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tbl_wr_r,
   input  logic [ID_W-1:0]  tbl_wr_id_r,
   input  logic [W-1:0]     tbl_wr_word_r,
   input  logic             tbl_rd_r,
   input  logic [ID_W-1:0]  tbl_rd_id_r,
   input  logic [TAG_W-1:0] tbl_rd_itag_r,
   output logic             tbl_rd_word_vld_r,
   output logic [W-1:0]     tbl_rd_word_r,
   output logic [TAG_W-1:0] tbl_rd_ctag_r,
   output logic [CNT_W-1:0] tbl_inflight_r
);

   localparam int unsigned DEPTH = 1 << ID_W;

   typedef logic [W-1:0]     word_t;
   typedef logic [ID_W-1:0]  id_t;
   typedef logic [TAG_W-1:0] tag_t;

   word_t            mem_q [DEPTH];
   word_t            mem_d [DEPTH];
   logic [LAT-1:0]   vld_q, vld_d;
   id_t              id_q   [LAT];
   id_t              id_d   [LAT];
   tag_t             tag_q  [LAT];
   tag_t             tag_d  [LAT];
   word_t            data_q [LAT];
   word_t            data_d [LAT];
   logic [CNT_W-1:0] inflight_q, inflight_d;

   always_comb begin : mem_next
      mem_d = mem_q;
      if (tbl_wr_r) begin
         mem_d[tbl_wr_id_r] = tbl_wr_word_r;
      end
   end

   // Valid always advances; payload only moves behind a valid so the output stage holds.
   always_comb begin : pipe_next
      vld_d[0]  = tbl_rd_r;
      id_d[0]   = id_q[0];
      tag_d[0]  = tag_q[0];
      data_d[0] = data_q[0];
      if (tbl_rd_r) begin
         id_d[0]   = tbl_rd_id_r;
         tag_d[0]  = tbl_rd_itag_r;
         data_d[0] = mem_q[tbl_rd_id_r];
      end
      for (int k = 1; k < int'(LAT); k++) begin
         vld_d[k]  = vld_q[k-1];
         id_d[k]   = id_q[k];
         tag_d[k]  = tag_q[k];
         data_d[k] = data_q[k];
         if (vld_q[k-1]) begin
            id_d[k]   = id_q[k-1];
            tag_d[k]  = tag_q[k-1];
            data_d[k] = data_q[k-1];
         end
      end
`ifdef RMW_LONG_LATENCY_TBL_SNOOP_EN
      // Write-first: every stage holding a valid read of the written id takes the new word.
      for (int k = 0; k < int'(LAT); k++) begin
         if (tbl_wr_r && vld_d[k] && (id_d[k] == tbl_wr_id_r)) begin
            data_d[k] = tbl_wr_word_r;
         end
      end
`endif
   end

   always_comb begin : cnt_next
      inflight_d = inflight_q + CNT_W'(tbl_rd_r) - CNT_W'(vld_q[LAT-1]);
   end

   always_ff @(posedge clk) begin : regs
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         vld_q <= '0;
         for (int k = 0; k < int'(LAT); k++) begin
            id_q[k]   <= '0;
            tag_q[k]  <= '0;
            data_q[k] <= '0;
         end
         inflight_q <= '0;
      end else begin
         mem_q      <= mem_d;
         vld_q      <= vld_d;
         id_q       <= id_d;
         tag_q      <= tag_d;
         data_q     <= data_d;
         inflight_q <= inflight_d;
      end
   end

   assign tbl_rd_word_vld_r = vld_q[LAT-1];
   assign tbl_rd_word_r     = data_q[LAT-1];
   assign tbl_rd_ctag_r     = tag_q[LAT-1];
   assign tbl_inflight_r    = inflight_q;

endmodule

// File: tb/tb_rmw_long_latency_tbl.sv
// Scoreboard bench for rmw_long_latency_tbl: queued expectations, cycle-based monitor.
module tb_rmw_long_latency_tbl;

   localparam int unsigned W     = 32;
   localparam int unsigned ID_W  = 4;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned LAT   = 4;
   localparam int unsigned CNT_W = $clog2(LAT + 1) + 1;
   localparam int unsigned DEPTH = 1 << ID_W;

   typedef struct {
      logic [ID_W-1:0]  id;
      logic [TAG_W-1:0] tag;
      logic [W-1:0]     word;
      int               ret;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             tbl_wr_r = 1'b0;
   logic [ID_W-1:0]  tbl_wr_id_r = '0;
   logic [W-1:0]     tbl_wr_word_r = '0;
   logic             tbl_rd_r = 1'b0;
   logic [ID_W-1:0]  tbl_rd_id_r = '0;
   logic [TAG_W-1:0] tbl_rd_itag_r = '0;
   logic             tbl_rd_word_vld_r;
   logic [W-1:0]     tbl_rd_word_r;
   logic [TAG_W-1:0] tbl_rd_ctag_r;
   logic [CNT_W-1:0] tbl_inflight_r;

   exp_t             q[$];
   logic [W-1:0]     mmem [DEPTH];
   logic [W-1:0]     last_word = '0;
   logic [TAG_W-1:0] last_tag  = '0;
   int               cyc = 0;
   int               checks = 0;
   int               errors = 0;
   int               peak = 0;

   rmw_long_latency_tbl #(.W(W), .ID_W(ID_W), .TAG_W(TAG_W), .LAT(LAT)) dut (
      .clk               (clk),
      .rst               (rst),
      .tbl_wr_r          (tbl_wr_r),
      .tbl_wr_id_r       (tbl_wr_id_r),
      .tbl_wr_word_r     (tbl_wr_word_r),
      .tbl_rd_r          (tbl_rd_r),
      .tbl_rd_id_r       (tbl_rd_id_r),
      .tbl_rd_itag_r     (tbl_rd_itag_r),
      .tbl_rd_word_vld_r (tbl_rd_word_vld_r),
      .tbl_rd_word_r     (tbl_rd_word_r),
      .tbl_rd_ctag_r     (tbl_rd_ctag_r),
      .tbl_inflight_r    (tbl_inflight_r)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: a return due this cycle must be presented, in order, with the scoreboard's word.
   always @(negedge clk) begin
      if (!rst) begin
         int exp_inf;
         exp_inf = 0;
         foreach (q[i]) if (q[i].ret < cyc + int'(LAT)) exp_inf++;
         chk("inflight", 64'(tbl_inflight_r), 64'(exp_inf));
         if (int'(tbl_inflight_r) > peak) peak = int'(tbl_inflight_r);
         if (tbl_rd_word_vld_r) begin
            if (q.size() == 0) begin
               chk("spurious_vld", 64'(1), 64'(0));
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("ret_cycle", 64'(cyc), 64'(e.ret));
               chk("ctag", 64'(tbl_rd_ctag_r), 64'(e.tag));
               chk("word", 64'(tbl_rd_word_r), 64'(e.word));
            end
            last_word = tbl_rd_word_r;
            last_tag  = tbl_rd_ctag_r;
         end else begin
            chk("hold_word", 64'(tbl_rd_word_r), 64'(last_word));
            chk("hold_ctag", 64'(tbl_rd_ctag_r), 64'(last_tag));
            chk("missing_ret", 64'(q.size() > 0 && q[0].ret <= cyc), 64'(0));
            if (q.size() > 0 && q[0].ret <= cyc) void'(q.pop_front());
         end
      end
   end

   // One cycle of stimulus plus the reference model: reads see the table as it stood
   // before their edge; with snoop, pending reads also see every later write to their id.
   task automatic step(input logic rd, input int rid, input int tag,
                       input logic wr, input int wid, input logic [W-1:0] wword);
      exp_t e;
      tbl_rd_r      = rd;
      tbl_rd_id_r   = rd ? ID_W'(rid) : ID_W'($urandom);
      tbl_rd_itag_r = rd ? TAG_W'(tag) : TAG_W'($urandom);
      tbl_wr_r      = wr;
      tbl_wr_id_r   = wr ? ID_W'(wid) : ID_W'($urandom);
      tbl_wr_word_r = wr ? wword : W'($urandom);
      if (rd) begin
         e.id   = ID_W'(rid);
         e.tag  = TAG_W'(tag);
         e.word = mmem[ID_W'(rid)];
         e.ret  = cyc + int'(LAT);
         q.push_back(e);
      end
      if (wr) begin
`ifdef RMW_LONG_LATENCY_TBL_SNOOP_EN
         for (int i = 0; i < q.size(); i++) begin
            if (q[i].ret > cyc && q[i].id == ID_W'(wid)) begin
               e = q[i];
               e.word = wword;
               q[i] = e;
            end
         end
`endif
         mmem[ID_W'(wid)] = wword;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0, '0);
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b1;
      tbl_rd_r = 1'b0;
      tbl_wr_r = 1'b0;
      q.delete();
      for (int i = 0; i < int'(DEPTH); i++) mmem[i] = '0;
      last_word = '0;
      last_tag  = '0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      #1;
      do_reset(2);
      chk("rst_vld", 64'(tbl_rd_word_vld_r), 64'(0));
      chk("rst_word", 64'(tbl_rd_word_r), 64'(0));
      chk("rst_inflight", 64'(tbl_inflight_r), 64'(0));

      // Sweep all ids back-to-back after reset.
      peak = 0;
      for (int i = 0; i < int'(DEPTH); i++) step(1'b1, i, i, 1'b0, 0, '0);
      idle(int'(LAT) + 2);
      chk("peak_inflight", 64'(peak), 64'(LAT));

      // Write then read next cycle.
      step(1'b0, 0, 0, 1'b1, 3, 32'hDEADBEEF);
      step(1'b1, 3, 7, 1'b0, 0, '0);
      idle(int'(LAT) + 1);

      // Write landing while the read is in flight.
      step(1'b0, 0, 0, 1'b1, 5, 32'h11);
      step(1'b1, 5, 2, 1'b0, 0, '0);
      idle(1);
      step(1'b0, 0, 0, 1'b1, 5, 32'h22);
      idle(int'(LAT) + 1);
      step(1'b1, 5, 3, 1'b0, 0, '0);
      idle(int'(LAT) + 1);

      // Read and write of the same id on the same edge.
      step(1'b0, 0, 0, 1'b1, 9, 32'hAA);
      step(1'b1, 9, 4, 1'b1, 9, 32'hBB);
      idle(int'(LAT) + 1);

      // Reset with reads in flight: nothing may return, table reads back zero.
      step(1'b1, 3, 1, 1'b0, 0, '0);
      step(1'b1, 5, 2, 1'b0, 0, '0);
      step(1'b1, 9, 3, 1'b0, 0, '0);
      do_reset(1);
      idle(int'(LAT) + 2);
      step(1'b1, 3, 5, 1'b0, 0, '0);
      step(1'b1, 5, 6, 1'b0, 0, '0);
      step(1'b1, 9, 8, 1'b0, 0, '0);
      idle(int'(LAT) + 1);

      // Read and write the same id every cycle.
      for (int i = 0; i < 8; i++) step(1'b1, 6, i, 1'b1, 6, W'(i + 1));
      idle(int'(LAT) + 1);

      // Random traffic over a few ids to force collisions.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), W'($urandom));
      end
      idle(int'(LAT) + 3);
      chk("drained", 64'(q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
